// File: rtl/ysyx_22040175_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22040175_mem_pkg
// Brief    : Shared memory-interface types and constants for the core's
//            fetch/mem stages and the SRAM responder.
// Revision : 1.0 - initial release
// ============================================================================
package ysyx_22040175_mem_pkg;

    localparam logic [31:0] c_DEFAULT_ADDR_BASE = 32'h8000_0000;
    localparam int          c_DATA_W            = 64;
    localparam int          c_MASK_W            = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/ysyx_22040175_lfsr16.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22040175_lfsr16
// Brief    : 16-bit Galois LFSR (taps 16,14,13,11) with step enable and
//            seed load; used to jitter the responder's latency.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22040175_lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    input  logic        i_load,
    input  logic [15:0] i_seed,
    output logic [15:0] o_q
);

    localparam logic [15:0] c_TAPS = 16'hB400;

    logic [15:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= SEED;
        end else if (i_load) begin
            r_q <= i_seed;
        end else if (i_en) begin
            r_q <= {1'b0, r_q[15:1]} ^ (r_q[0] ? c_TAPS : 16'h0000);
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/ysyx_22040175_sram_rsp.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22040175_sram_rsp
// Brief    : Single-port 64-bit memory responder with fixed-latency
//            valid/ready request/response handshake and byte-masked writes.
//            Define YSYX_22040175_SRAM_RSP_RAND_DELAY_EN to add 0..3 random
//            extra wait cycles per request.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22040175_sram_rsp
    import ysyx_22040175_mem_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE = c_DEFAULT_ADDR_BASE,
    parameter int          DEPTH     = 4096,
    parameter int          LATENCY   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wen,
    input  logic [31:0]         req_addr,
    input  logic [c_DATA_W-1:0] req_wdata,
    input  logic [c_MASK_W-1:0] req_wmask,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [c_DATA_W-1:0] rsp_rdata,
    output logic                rsp_err
);

    localparam int          c_IDX_W = $clog2(DEPTH);
    localparam int          c_CNT_W = 5;
    localparam logic [32:0] c_SPAN  = 33'(DEPTH) << 3;

    state_e               r_state;
    state_e               w_next;
    logic                 w_commit;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_total;
    logic [1:0]           w_extra;

    logic                 r_wen;
    logic                 r_in_range;
    logic [c_IDX_W-1:0]   r_idx;
    logic [c_DATA_W-1:0]  r_wdata;
    logic [c_MASK_W-1:0]  r_wmask;

    logic [c_DATA_W-1:0]  r_mem [DEPTH];

    // 33-bit offset: a borrow sets bit 32, so addresses below the base fail
    logic [32:0]          w_off;
    logic                 w_in_range_in;
    logic [c_IDX_W-1:0]   w_idx_in;

    assign w_off         = {1'b0, req_addr} - {1'b0, ADDR_BASE};
    assign w_in_range_in = (w_off < c_SPAN);
    assign w_idx_in      = w_off[c_IDX_W+2:3];

`ifdef YSYX_22040175_SRAM_RSP_RAND_DELAY_EN
    logic [15:0] w_lfsr;
    logic        w_lfsr_unused;

    ysyx_22040175_lfsr16 #(
        .SEED (16'hACE1)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .i_en   (1'b1),
        .i_load (1'b0),
        .i_seed (16'hACE1),
        .o_q    (w_lfsr)
    );

    assign w_extra       = w_lfsr[1:0];
    assign w_lfsr_unused = &{1'b0, w_lfsr[15:2]};
`else
    assign w_extra = 2'd0;
`endif

    assign w_total   = c_CNT_W'(LATENCY) + c_CNT_W'(w_extra);
    assign req_ready = (r_state == IDLE) && !rst;
    assign rsp_valid = (r_state == RESP);

    // A zero-latency commit happens on the accept edge, so take the live request
    logic                 w_c_wen;
    logic                 w_c_in_range;
    logic [c_IDX_W-1:0]   w_c_idx;
    logic [c_DATA_W-1:0]  w_c_wdata;
    logic [c_MASK_W-1:0]  w_c_wmask;

    assign w_c_wen      = (r_state == IDLE) ? req_wen       : r_wen;
    assign w_c_in_range = (r_state == IDLE) ? w_in_range_in : r_in_range;
    assign w_c_idx      = (r_state == IDLE) ? w_idx_in      : r_idx;
    assign w_c_wdata    = (r_state == IDLE) ? req_wdata     : r_wdata;
    assign w_c_wmask    = (r_state == IDLE) ? req_wmask     : r_wmask;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_commit = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (w_total == '0) begin
                        w_next   = RESP;
                        w_commit = 1'b1;
                    end else begin
                        w_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_next   = RESP;
                    w_commit = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            r_wen      <= 1'b0;
            r_in_range <= 1'b0;
            r_idx      <= '0;
            r_wdata    <= '0;
            r_wmask    <= '0;
        end else begin
            if (r_state == IDLE && req_valid) begin
                r_wen      <= req_wen;
                r_in_range <= w_in_range_in;
                r_idx      <= w_idx_in;
                r_wdata    <= req_wdata;
                r_wmask    <= req_wmask;
                if (w_total != '0) begin
                    r_cnt <= w_total - 1'b1;
                end
            end else if (r_state == WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_commit) begin
                rsp_err   <= !w_c_in_range;
                rsp_rdata <= (w_c_in_range && !w_c_wen) ? r_mem[w_c_idx] : '0;
            end
        end
    end

    // Storage is deliberately not reset; rst only blocks a pending commit
    always_ff @(posedge clk) begin
        if (!rst && w_commit && w_c_in_range && w_c_wen) begin
            for (int i = 0; i < c_MASK_W; i++) begin
                if (w_c_wmask[i]) begin
                    r_mem[w_c_idx][8*i +: 8] <= w_c_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22040175_sram_rsp.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_22040175_sram_rsp
// Brief    : Directed self-checking bench for the SRAM responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_22040175_sram_rsp;

    localparam logic [31:0] c_B = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wmask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    int n_vec = 0;
    int n_err = 0;

    ysyx_22040175_sram_rsp dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wen   (req_wen),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wmask (req_wmask),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full transaction; lat counts negedges from acceptance to rsp_valid
    task automatic xact(input logic wen, input logic [31:0] addr, input logic [63:0] wd,
                        input logic [7:0] wm, output logic [63:0] rd, output logic er,
                        output int lat);
        int guard;
        @(negedge clk);
        req_wen   = wen;
        req_addr  = addr;
        req_wdata = wd;
        req_wmask = wm;
        req_valid = 1'b1;
        guard = 0;
        while (!req_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        rd = rsp_rdata;
        er = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    logic [63:0] rd;
    logic        er;
    int          lat;
    logic        seen;

`ifdef YSYX_22040175_SRAM_RSP_RAND_DELAY_EN
    logic [63:0] mdl [16];
`endif

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_wen   = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wmask = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rdata", rsp_rdata, 64'd0);
        chk("rst_err", 64'(rsp_err), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_req_ready", 64'(req_ready), 64'd1);

        // Preload through the port
        xact(1'b1, c_B, 64'h1122_3344_5566_7788, 8'hFF, rd, er, lat);
        chk("wr0_rdata", rd, 64'd0);
        chk("wr0_err", 64'(er), 64'd0);
        chk("wr0_lat", 64'(lat), 64'd3);
        xact(1'b1, c_B + 32'h8, 64'd0, 8'hFF, rd, er, lat);
        xact(1'b1, c_B + 32'h10, 64'hDEAD_BEEF_0BAD_F00D, 8'hFF, rd, er, lat);
        xact(1'b1, 32'h8000_7FF8, 64'h0123_4567_89AB_CDEF, 8'hFF, rd, er, lat);

        xact(1'b0, c_B, 64'd0, 8'h00, rd, er, lat);
        chk("rd0_rdata", rd, 64'h1122_3344_5566_7788);
        chk("rd0_err", 64'(er), 64'd0);
        chk("rd0_lat", 64'(lat), 64'd3);

        xact(1'b1, c_B + 32'h8, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, rd, er, lat);
        xact(1'b0, c_B + 32'h8, 64'd0, 8'h00, rd, er, lat);
        chk("mask0F_rdata", rd, 64'h0000_0000_FFFF_FFFF);

        xact(1'b1, c_B + 32'h8, 64'h5555_5555_5555_5555, 8'h00, rd, er, lat);
        chk("nomask_err", 64'(er), 64'd0);
        xact(1'b0, c_B + 32'h8, 64'd0, 8'h00, rd, er, lat);
        chk("nomask_rdata", rd, 64'h0000_0000_FFFF_FFFF);

        xact(1'b1, c_B + 32'h8, 64'hAABB_CCDD_EEFF_0011, 8'h81, rd, er, lat);
        xact(1'b0, c_B + 32'h8, 64'd0, 8'h00, rd, er, lat);
        chk("mask81_rdata", rd, 64'hAA00_0000_FFFF_FF11);

        // Range boundaries
        xact(1'b0, 32'h8000_7FF8, 64'd0, 8'h00, rd, er, lat);
        chk("top_rdata", rd, 64'h0123_4567_89AB_CDEF);
        chk("top_err", 64'(er), 64'd0);
        xact(1'b0, 32'h7FFF_FFF8, 64'd0, 8'h00, rd, er, lat);
        chk("below_err", 64'(er), 64'd1);
        chk("below_rdata", rd, 64'd0);
        xact(1'b0, 32'h8000_8000, 64'd0, 8'h00, rd, er, lat);
        chk("above_err", 64'(er), 64'd1);
        chk("above_rdata", rd, 64'd0);
        xact(1'b1, 32'h8000_8000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, rd, er, lat);
        chk("above_wr_err", 64'(er), 64'd1);
        xact(1'b1, 32'h7FFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, rd, er, lat);
        chk("below_wr_err", 64'(er), 64'd1);
        xact(1'b0, c_B, 64'd0, 8'h00, rd, er, lat);
        chk("alias_lo_rdata", rd, 64'h1122_3344_5566_7788);
        xact(1'b0, 32'h8000_7FF8, 64'd0, 8'h00, rd, er, lat);
        chk("alias_hi_rdata", rd, 64'h0123_4567_89AB_CDEF);

        // Back-pressure: response held, second request blocked
        @(negedge clk);
        req_wen   = 1'b0;
        req_addr  = c_B + 32'h10;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("stall_lat", 64'(lat), 64'd3);
        req_addr  = c_B;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 64'(rsp_valid), 64'd1);
            chk("stall_rdata", rsp_rdata, 64'hDEAD_BEEF_0BAD_F00D);
            chk("stall_err", 64'(rsp_err), 64'd0);
            chk("stall_req_ready", 64'(req_ready), 64'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("post_hs_req_ready", 64'(req_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("second_lat", 64'(lat), 64'd3);
        chk("second_rdata", rsp_rdata, 64'h1122_3344_5566_7788);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;

        // Reset on the cycle the write would commit
        req_wen   = 1'b1;
        req_addr  = c_B + 32'h10;
        req_wdata = 64'd0;
        req_wmask = 8'hFF;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        chk("rstwait_no_rsp", 64'(seen), 64'd0);
        xact(1'b0, c_B + 32'h10, 64'd0, 8'h00, rd, er, lat);
        chk("rstwait_mem_kept", rd, 64'hDEAD_BEEF_0BAD_F00D);

`ifdef YSYX_22040175_SRAM_RSP_RAND_DELAY_EN
        for (int i = 0; i < 16; i++) begin
            mdl[i] = {32'(i), 32'hC0DE_0000 | 32'(i)};
            xact(1'b1, c_B + 32'(i * 8), mdl[i], 8'hFF, rd, er, lat);
        end
        for (int n = 0; n < 1000; n++) begin
            logic        w;
            int          k;
            logic [63:0] d;
            logic [7:0]  m;
            logic [63:0] exp_rd;
            w = 1'($urandom_range(0, 1));
            k = int'($urandom_range(0, 15));
            d = {$urandom, $urandom};
            m = 8'($urandom_range(0, 255));
            exp_rd = w ? 64'd0 : mdl[k];
            xact(w, c_B + 32'(k * 8), d, m, rd, er, lat);
            chk("rand_rdata", rd, exp_rd);
            chk("rand_lat_range", 64'(lat >= 3 && lat <= 6), 64'd1);
            if (w) begin
                for (int b = 0; b < 8; b++) begin
                    if (m[b]) mdl[k][8*b +: 8] = d[8*b +: 8];
                end
            end
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
